writeback_stage: RTL

Final MIPS pipeline stage. It latches the MEM/WB bundle, selects the write-back value, and drives the register-file write port that the ID stage consumes as i_control_write_reg, i_reg_write and i_data_write. It also extracts and extends sub-word load data, tracks halt retirement, and counts retired instructions for the debug database.

---
 rtl/writeback_stage.sv | 134 +++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// MIPS write-back stage: latches MEM/WB, extracts sub-word loads, drives the register-file write port.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage #(
    parameter int unsigned CANT_REGISTROS      = 32,
    parameter int unsigned CANT_BITS_REGISTROS = 32,
    parameter int unsigned CANT_BITS_ADDR      = 11,
    parameter int unsigned CANT_BITS_COUNTER   = 32
) (
    input  logic                                  i_clock,
    input  logic                                  i_soft_reset,
    input  logic                                  i_enable_pipeline,
    input  logic                                  i_enable_etapa,
    input  logic                                  i_RegWrite,
    input  logic                                  i_MemtoReg,
    input  logic                                  i_link,
    input  logic [1:0]                            i_mem_size,
    input  logic                                  i_mem_unsigned,
    input  logic [1:0]                            i_addr_lsb,
    input  logic [CANT_BITS_REGISTROS-1:0]        i_alu_result,
    input  logic [CANT_BITS_REGISTROS-1:0]        i_mem_data,
    input  logic [CANT_BITS_ADDR-1:0]             i_return_addr,
    input  logic [$clog2(CANT_REGISTROS)-1:0]     i_reg_dest,
    input  logic                                  i_halt_detected,
    output logic                                  o_control_write_reg,
    output logic [$clog2(CANT_REGISTROS)-1:0]     o_reg_write,
    output logic [CANT_BITS_REGISTROS-1:0]        o_data_write,
    output logic                                  o_halt_done,
    output logic [CANT_BITS_COUNTER-1:0]          o_retired_count
);
    localparam int unsigned RW = $clog2(CANT_REGISTROS);
    localparam int unsigned DW = CANT_BITS_REGISTROS;
    localparam int unsigned CW = CANT_BITS_COUNTER;
    localparam int unsigned BW = 8;
    localparam int unsigned HW = 16;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            adv;
    logic [BW-1:0]   byte_sel;
    logic [HW-1:0]   half_sel;
    logic [DW-1:0]   load_data;
    logic [DW-1:0]   wb_data;
    logic            wen_next;
    logic [RW-1:0]   addr_next;
    logic [DW-1:0]   data_next;
    logic            halt_next;

    assign adv = i_enable_pipeline & i_enable_etapa & (state == S_RUN);

    // Little-endian sub-word extraction; half-word ignores the byte-offset LSB.
    always_comb begin
        byte_sel  = BW'(i_mem_data >> {i_addr_lsb, 3'b000});
        half_sel  = i_addr_lsb[1] ? i_mem_data[2*HW-1:HW] : i_mem_data[HW-1:0];
        load_data = i_mem_data;
        if (!i_mem_size[1]) begin
            if (i_mem_size[0]) begin
                load_data = {{(DW-HW){half_sel[HW-1] & ~i_mem_unsigned}}, half_sel};
            end else begin
                load_data = {{(DW-BW){byte_sel[BW-1] & ~i_mem_unsigned}}, byte_sel};
            end
        end
    end

    // Write-back source priority: link, then load, then ALU.
    always_comb begin
        wb_data = i_alu_result;
        if (i_link) begin
            wb_data = DW'(i_return_addr);
        end else if (i_MemtoReg) begin
            wb_data = load_data;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next = state;
        wen_next   = 1'b0;
        addr_next  = o_reg_write;
        data_next  = o_data_write;
        halt_next  = o_halt_done;
        case (state)
            S_RUN: begin
                if (adv) begin
                    if (i_halt_detected) begin
                        state_next = S_HALTED;
                        halt_next  = 1'b1;
                    end else begin
                        wen_next  = i_RegWrite & (i_reg_dest != '0);
                        addr_next = i_reg_dest;
                        data_next = wb_data;
                    end
                end
            end
            S_HALTED: begin
                halt_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state               <= S_RUN;
            o_control_write_reg <= 1'b0;
            o_reg_write         <= '0;
            o_data_write        <= '0;
            o_halt_done         <= 1'b0;
        end else begin
            state               <= state_next;
            o_control_write_reg <= wen_next;
            o_reg_write         <= addr_next;
            o_data_write        <= data_next;
            o_halt_done         <= halt_next;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    // Counts every advancing edge, bubbles and the HALT itself included.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            o_retired_count <= '0;
        end else if (adv) begin
            o_retired_count <= o_retired_count + CW'(1);
        end
    end
`else
    assign o_retired_count = '0;
`endif

endmodule
